// File: rtl/tile_map_pkg.sv
// Shared constants, state encoding and address helper
// for the VGA tile-map engine.
package tile_map_pkg;

    localparam int DEF_COLS       = 20;
    localparam int DEF_ROWS       = 15;
    localparam int DEF_TILE_SHIFT = 5;
    localparam int DEF_IDX_W      = 4;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    function automatic int addr_w(input int cols, input int rows);
        return (cols * rows > 1) ? $clog2(cols * rows) : 1;
    endfunction

endpackage

// File: rtl/tile_map_ram.sv
// Tile index register array: per-entry reset value,
// one synchronous write port, one registered read port.
module tile_map_ram
    import tile_map_pkg::*;
#(
    parameter int DEPTH      = DEF_COLS * DEF_ROWS,
    parameter int AW         = addr_w(DEF_COLS, DEF_ROWS),
    parameter int IDX_W      = DEF_IDX_W,
    parameter int RESET_TILE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [IDX_W-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [IDX_W-1:0] rd_data
);

    logic [IDX_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= IDX_W'(RESET_TILE);
            end
        end else if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking read: a same-edge write is not seen
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/tile_map_engine.sv
// Tile-map store with single writes, bulk fill sweep and
// a two-stage per-pixel tile lookup for the VGA path.
module tile_map_engine
    import tile_map_pkg::*;
#(
    parameter int COLS       = DEF_COLS,
    parameter int ROWS       = DEF_ROWS,
    parameter int TILE_SHIFT = DEF_TILE_SHIFT,
    parameter int IDX_W      = DEF_IDX_W,
    parameter int RESET_TILE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [9:0]              h_cnt,
    input  logic [9:0]              v_cnt,
    input  logic                    valid,
    input  logic                    wr_en,
    input  logic [$clog2(COLS)-1:0] wr_col,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [IDX_W-1:0]        wr_idx,
    output logic                    wr_ready,
    input  logic                    fill_req,
    input  logic [IDX_W-1:0]        fill_idx,
    output logic                    fill_busy,
    output logic                    fill_done,
    output logic                    out_valid,
    output logic [IDX_W-1:0]        out_idx,
    output logic [TILE_SHIFT-1:0]   out_px_x,
    output logic [TILE_SHIFT-1:0]   out_px_y
);

    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int AW    = addr_w(COLS, ROWS);
    localparam int DEPTH = COLS * ROWS;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [AW-1:0]    ptr;
    logic [IDX_W-1:0] fill_val;

    logic             ram_we;
    logic [AW-1:0]    ram_wr_addr;
    logic [IDX_W-1:0] ram_wr_data;
    logic [AW-1:0]    ram_rd_addr;
    logic [IDX_W-1:0] ram_rd_data;

    logic             wr_in_map;
    logic             wr_ok;
    logic [AW-1:0]    wr_addr;

    logic [9:0]       h_tile;
    logic [9:0]       v_tile;
    logic             pix_in;

    logic [CW-1:0]         s1_col;
    logic [RW-1:0]         s1_row;
    logic [TILE_SHIFT-1:0] s1_px_x;
    logic [TILE_SHIFT-1:0] s1_px_y;
    logic                  s1_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (fill_req) state_nx = FILL;
            FILL: if (ptr == LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign fill_busy = (state == FILL);
    assign wr_ready  = (state == IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr       <= '0;
            fill_val  <= '0;
            fill_done <= 1'b0;
        end else begin
            fill_done <= fill_busy && (ptr == LAST);
            if (!fill_busy && fill_req) begin
                ptr      <= '0;
                fill_val <= fill_idx;
            end else if (fill_busy) begin
                ptr <= ptr + 1'b1;
            end
        end
    end

    assign wr_in_map = ({1'b0, wr_col} < (CW + 1)'(COLS))
                    && ({1'b0, wr_row} < (RW + 1)'(ROWS));
    assign wr_ok     = wr_en && wr_ready && wr_in_map;
    assign wr_addr   = AW'(wr_row) * AW'(COLS) + AW'(wr_col);

    // Fill sweep owns the write port while busy
    always_comb begin
        ram_we      = wr_ok;
        ram_wr_addr = wr_addr;
        ram_wr_data = wr_idx;
        if (fill_busy) begin
            ram_we      = 1'b1;
            ram_wr_addr = ptr;
            ram_wr_data = fill_val;
        end
    end

    assign h_tile = h_cnt >> TILE_SHIFT;
    assign v_tile = v_cnt >> TILE_SHIFT;
    assign pix_in = valid
                 && ({1'b0, h_tile} < 11'(COLS))
                 && ({1'b0, v_tile} < 11'(ROWS));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_col  <= '0;
            s1_row  <= '0;
            s1_px_x <= '0;
            s1_px_y <= '0;
            s1_in   <= 1'b0;
        end else begin
            s1_in <= pix_in;
            if (pix_in) begin
                s1_col  <= CW'(h_tile);
                s1_row  <= RW'(v_tile);
                s1_px_x <= h_cnt[TILE_SHIFT-1:0];
                s1_px_y <= v_cnt[TILE_SHIFT-1:0];
            end else begin
                s1_col  <= '0;
                s1_row  <= '0;
                s1_px_x <= '0;
                s1_px_y <= '0;
            end
        end
    end

    assign ram_rd_addr = AW'(s1_row) * AW'(COLS) + AW'(s1_col);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_px_x  <= '0;
            out_px_y  <= '0;
        end else begin
            out_valid <= s1_in;
            out_px_x  <= s1_px_x;
            out_px_y  <= s1_px_y;
        end
    end

    // Out-of-map pixels read entry 0; mask it off
    assign out_idx = out_valid ? ram_rd_data : '0;

    tile_map_ram #(
        .DEPTH      (DEPTH),
        .AW         (AW),
        .IDX_W      (IDX_W),
        .RESET_TILE (RESET_TILE)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (ram_we),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data)
    );

endmodule

// File: doc/tile_map_engine.md
# tile_map_engine

Parametrised tile-map store and per-pixel lookup for the VGA path. Holds a COLS×ROWS grid of tile indices, resets every entry to a fixed tile and accepts single-tile writes plus a bulk fill sweep. For each pixel it maps the VGA controller's h_cnt/v_cnt to a tile index and in-tile coordinates for the downstream pixel/ROM stage. It replaces the fixed 20×15 combinational map at the top level.

## Interface
Parameters:
- COLS, 20, tiles per row
- ROWS, 15, tiles per column
- TILE_SHIFT, 5, log2 of tile edge in pixels (32 px)
- IDX_W, 4, tile index width
- RESET_TILE, 1, index loaded into every entry on reset

Ports:
- clk  in  1  pixel clock, 25 MHz domain
- rst  in  1  asynchronous, active-low reset
- h_cnt  in  10  horizontal pixel count from the VGA controller
- v_cnt  in  10  vertical pixel count from the VGA controller
- valid  in  1  active-video flag from the VGA controller
- wr_en  in  1  single-tile write strobe
- wr_col  in  $clog2(COLS)  write column
- wr_row  in  $clog2(ROWS)  write row
- wr_idx  in  IDX_W  tile index to write
- wr_ready  out  1  high when a write is accepted
- fill_req  in  1  start bulk fill
- fill_idx  in  IDX_W  fill value
- fill_busy  out  1  fill sweep in progress
- fill_done  out  1  one-cycle pulse on the last fill write
- out_valid  out  1  pixel lies inside the map and valid was high
- out_idx  out  IDX_W  tile index at the pixel
- out_px_x  out  TILE_SHIFT  x offset within the tile
- out_px_y  out  TILE_SHIFT  y offset within the tile

## Operation
- Reset (rst=0, asynchronous): all map entries = RESET_TILE; state IDLE; fill pointer 0; all outputs 0 except wr_ready=1.
- FSM states are IDLE and FILL.
  - IDLE → FILL on a clock edge with fill_req=1. That edge latches fill_idx and sets ptr=0.
  - In FILL, each edge writes entry ptr (row-major, ptr = row*COLS+col) and increments ptr.
  - The edge that writes ptr=COLS*ROWS-1 returns the FSM to IDLE and sets fill_done=1 for one cycle.
  - fill_req while in FILL is ignored.
- fill_busy = (state==FILL). wr_ready = (state==IDLE).
- A write is accepted when wr_en && wr_ready. Writes with wr_col≥COLS or wr_row≥ROWS are dropped silently. wr_en during FILL is dropped.
- If wr_en and fill_req arrive in the same IDLE cycle, the write is applied first and the fill starts. The fill then overwrites it.
- Lookup: col = h_cnt>>TILE_SHIFT, row = v_cnt>>TILE_SHIFT, px_x/px_y = low TILE_SHIFT bits.
  - In range means valid && col<COLS && row<ROWS.
  - Out of range: out_valid=0, out_idx=0, px outputs 0.
- Read and write of the same entry on the same edge: the lookup returns the old value.

## Timing
- Lookup latency is 2 cycles, fully pipelined, one pixel per cycle.
  - Stage 1 registers col, row, px offsets and the in-range flag.
  - Stage 2 reads the map and registers out_*.
- A single-tile write is visible to a lookup whose stage 2 falls on the cycle after the write edge.
- A fill takes exactly COLS*ROWS cycles of fill_busy=1. fill_done is asserted in the cycle after the final write edge, coincident with fill_busy=0.
- Reset mid-fill aborts the sweep. All entries go to RESET_TILE, with no fill_done.

## Structure
- Shared package tile_map_pkg holds:
  - default COLS/ROWS/TILE_SHIFT/IDX_W constants
  - the state enum {IDLE, FILL}
  - a helper giving the row-major address width, $clog2(COLS*ROWS)
- One sub-module, tile_map_ram: a register array with a per-entry reset value, one synchronous write port and one registered read port. The engine muxes the write port between the single-tile path and the fill sweep.

## Test plan
- Reset, then h=100, v=40, valid=1 → 2 cycles later: out_valid=1, out_idx=1, out_px_x=4, out_px_y=8.
- Write col=5, row=2, idx=9, then h=170, v=70 → out_idx=9, out_px_x=10, out_px_y=6. Neighbour tile (4,2) still reads 1.
- fill_req with fill_idx=7 → fill_busy high for 300 cycles, then one fill_done pulse. A wr_en during the sweep is dropped (wr_ready=0). Afterwards all 300 tiles read 7.
- h=650, v=40, valid=1 → out_valid=0, out_idx=0. Write col=20 is dropped and no entry changes.
- Same-edge write idx=3 and lookup of the same tile → lookup returns the old value 1; the next lookup returns 3.
- rst low at ptr=150 during a fill of 7 → every entry reads 1, state IDLE, no fill_done pulse.
